// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory bus between the instruction-fetch stage (IF) and
// the MEM stage. At most one bus transaction is outstanding at a time. Data
// accesses win over fetches. Read data plus a one-cycle ready pulse go back
// to the winner. A watchdog aborts a transaction that never sees bus_ack.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   if_req/if_addr     fetch request (held until if_ready)
//   if_rdata/if_ready  fetched word and one-cycle completion pulse
//   mem_req/_we/_sel/_addr/_wdata   data request (held until mem_ready)
//   mem_rdata/mem_ready             load data and one-cycle completion pulse
//   flush              pipeline flush; suppresses delivery of a pending fetch
//   bus_req/_we/_sel/_addr/_wdata   registered master-side bus outputs
//   bus_rdata/bus_ack  slave read data and completion
//   bus_err            one-cycle pulse when the watchdog aborts
//   stall_req          combinational: some requester is still waiting
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,

    input  logic        flush,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,

    output logic        stall_req
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Watchdog value seen during the last permitted busy cycle. The counter
    // is zero in the first busy cycle, so it holds TIMEOUT-1 in the
    // TIMEOUT-th one.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [3:0]  bus_sel_q,   bus_sel_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q,   bus_err_d;
    logic        discard_q,   discard_d;
    logic [7:0]  wdog_q,      wdog_d;

    logic        finish;      // busy transaction ends this cycle (ack or abort)

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        discard_d   = discard_q;
        wdog_d      = wdog_q;
        // Ready and error are pulses: they only live for the DONE cycle.
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d     = MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    wdog_d      = 8'd0;
                end else if (if_req) begin
                    state_d    = IF_BUSY;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'hF;
                    bus_addr_d = if_addr;
                    wdog_d     = 8'd0;
                    // A flush in the grant cycle already kills this fetch.
                    discard_d  = flush;
                end
            end

            IF_BUSY, MEM_BUSY: begin
                wdog_d = wdog_q + 8'd1;
                if (state_q == IF_BUSY && flush) begin
                    discard_d = 1'b1;
                end
                // Ack wins over a coincident timeout.
                finish = bus_ack || (wdog_q == WDOG_LAST);
                if (finish) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = ~bus_ack;
                    if (state_q == MEM_BUSY) begin
                        mem_ready_d = 1'b1;
                        // Stores and aborted accesses return zero.
                        mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : 32'h0;
                    end else begin
                        // Uses discard_d so a flush in the final busy cycle
                        // still suppresses delivery.
                        if_ready_d = ~discard_d;
                        if_rdata_d = bus_ack ? bus_rdata : 32'h0;
                    end
                end
            end

            DONE: begin
                // Requests are deliberately not sampled here so requesters
                // get one edge to drop or change req after their ready.
                state_d   = IDLE;
                discard_d = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= 32'h0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            discard_q   <= 1'b0;
            wdog_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
            discard_q   <= discard_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;

    assign stall_req = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flush = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        bus_err;
    logic        stall_req;

    int n_chk  = 0;
    int n_fail = 0;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One transaction on the bus at a time; it ends on the first sampled ack
    // or after TO busy cycles, followed by one completion cycle where the
    // requesters are ignored.
    typedef struct {
        bit          is_mem;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          disc;
        int          age;
    } txn_t;

    txn_t        cur;
    bit          busy = 0;
    bit          cool = 0;
    logic        e_bus_req = 0, e_if_ready = 0, e_mem_ready = 0, e_err = 0;
    logic [31:0] e_if_rdata = 0, e_mem_rdata = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            busy = 0; cool = 0;
            e_bus_req = 0; e_if_ready = 0; e_mem_ready = 0; e_err = 0;
            e_if_rdata = 0; e_mem_rdata = 0;
        end else begin
            e_if_ready = 0; e_mem_ready = 0; e_err = 0;
            if (cool) begin
                cool = 0;
            end else if (busy) begin
                cur.age++;
                if (!cur.is_mem && flush) cur.disc = 1;
                if (bus_ack || cur.age == TO) begin
                    busy = 0; cool = 1; e_bus_req = 0; e_err = !bus_ack;
                    if (cur.is_mem) begin
                        e_mem_ready = 1;
                        e_mem_rdata = (bus_ack && !cur.we) ? bus_rdata : 32'h0;
                    end else if (!cur.disc) begin
                        e_if_ready = 1;
                        e_if_rdata = bus_ack ? bus_rdata : 32'h0;
                    end
                end
            end else if (mem_req) begin
                cur.is_mem = 1; cur.we = mem_we; cur.sel = mem_sel; cur.addr = mem_addr;
                cur.wdata = mem_wdata; cur.disc = 0; cur.age = 0;
                busy = 1; e_bus_req = 1;
            end else if (if_req) begin
                cur.is_mem = 0; cur.we = 0; cur.sel = 4'hF; cur.addr = if_addr;
                cur.wdata = 32'h0; cur.disc = flush; cur.age = 0;
                busy = 1; e_bus_req = 1;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        @(posedge clk);
        #1;
        chk("m_bus_req",   {31'h0, bus_req},   {31'h0, e_bus_req});
        chk("m_bus_err",   {31'h0, bus_err},   {31'h0, e_err});
        chk("m_if_ready",  {31'h0, if_ready},  {31'h0, e_if_ready});
        chk("m_mem_ready", {31'h0, mem_ready}, {31'h0, e_mem_ready});
        chk("m_stall_req", {31'h0, stall_req},
            {31'h0, (if_req & ~e_if_ready) | (mem_req & ~e_mem_ready)});
        if (e_bus_req) begin
            chk("m_bus_addr", bus_addr, cur.addr);
            chk("m_bus_we",   {31'h0, bus_we}, {31'h0, cur.we});
            chk("m_bus_sel",  {28'h0, bus_sel}, {28'h0, cur.sel});
            if (cur.is_mem && cur.we) chk("m_bus_wdata", bus_wdata, cur.wdata);
        end
        if (e_if_ready)  chk("m_if_rdata",  if_rdata,  e_if_rdata);
        if (e_mem_ready) chk("m_mem_rdata", mem_rdata, e_mem_rdata);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_bus_req",   {31'h0, bus_req},   32'h0);
        chk("rst_bus_sel",   {28'h0, bus_sel},   32'h0);
        chk("rst_bus_addr",  bus_addr,           32'h0);
        chk("rst_if_ready",  {31'h0, if_ready},  32'h0);
        chk("rst_mem_rdata", mem_rdata,          32'h0);
        rst = 1'b1;
        @(negedge clk);

        // ack while idle must be ignored
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("idle_ack", {29'h0, if_ready, mem_ready, bus_req}, 32'h0);
        bus_ack = 1'b0;

        // single fetch, ack in cycle 2
        if_req = 1'b1; if_addr = 32'h00400000;
        @(negedge clk);
        chk("f_c1_req",  {31'h0, bus_req}, 32'h1);
        chk("f_c1_addr", bus_addr, 32'h00400000);
        chk("f_c1_we",   {31'h0, bus_we}, 32'h0);
        @(negedge clk);
        chk("f_c2_addr", bus_addr, 32'h00400000);
        bus_ack = 1'b1; bus_rdata = 32'h24020005;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("f_c3_ready", {31'h0, if_ready}, 32'h1);
        chk("f_c3_rdata", if_rdata, 32'h24020005);
        if_req = 1'b0;
        @(negedge clk);
        chk("f_c4_idle", {30'h0, if_ready, bus_req}, 32'h0);

        // simultaneous: MEM first (zero wait, ack held into DONE), then fetch
        if_req = 1'b1; if_addr = 32'h00400004;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10010000;
        @(negedge clk);
        chk("s_c1_addr", bus_addr, 32'h10010000);
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        @(negedge clk);
        chk("s_c2_mready", {31'h0, mem_ready}, 32'h1);
        chk("s_c2_mrdata", mem_rdata, 32'h11112222);
        chk("s_c2_stall",  {31'h0, stall_req}, 32'h1);
        mem_req = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("s_c3_idle",  {31'h0, bus_req}, 32'h0);
        chk("s_c3_stall", {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        chk("s_c4_addr", bus_addr, 32'h00400004);
        bus_ack = 1'b1; bus_rdata = 32'h33334444;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("s_c5_iready", {31'h0, if_ready}, 32'h1);
        chk("s_c5_irdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        @(negedge clk);
        chk("s_c6_stall", {31'h0, stall_req}, 32'h0);

        // timeout with no ack
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10010010;
        repeat (4) @(negedge clk);
        chk("t_c4_req", {31'h0, bus_req}, 32'h1);
        chk("t_c4_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        chk("t_c5_err",    {31'h0, bus_err}, 32'h1);
        chk("t_c5_mready", {31'h0, mem_ready}, 32'h1);
        chk("t_c5_mrdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        @(negedge clk);
        chk("t_c6_err", {31'h0, bus_err}, 32'h0);

        // ack exactly on the last permitted busy cycle
        if_req = 1'b1; if_addr = 32'h0040000C;
        repeat (4) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h5A5A0F0F;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("a4_iready", {31'h0, if_ready}, 32'h1);
        chk("a4_irdata", if_rdata, 32'h5A5A0F0F);
        chk("a4_err",    {31'h0, bus_err}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);

        // store, ack after 3 wait cycles
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
        mem_addr = 32'h10010008; mem_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("st_we",    {31'h0, bus_we}, 32'h1);
            chk("st_sel",   {28'h0, bus_sel}, 32'h3);
            chk("st_wdata", bus_wdata, 32'hDEADBEEF);
        end
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("st_mready", {31'h0, mem_ready}, 32'h1);
        chk("st_mrdata", mem_rdata, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("st_mready_off", {31'h0, mem_ready}, 32'h0);

        // flush one cycle after the fetch grant
        if_req = 1'b1; if_addr = 32'h00400008;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("fl_c3_noready", {31'h0, if_ready}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        chk("fl_c4_idle", {30'h0, if_ready, bus_req}, 32'h0);

        // reset in the middle of a MEM transaction
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10010020;
        @(negedge clk);
        chk("r_busy", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("r_async_req",  {31'h0, bus_req}, 32'h0);
        chk("r_async_sel",  {28'h0, bus_sel}, 32'h0);
        chk("r_async_addr", bus_addr, 32'h0);
        chk("r_async_rdy",  {30'h0, if_ready, mem_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("r_new_req",  {31'h0, bus_req}, 32'h1);
        chk("r_new_addr", bus_addr, 32'h10010020);
        bus_ack = 1'b1; bus_rdata = 32'h77778888;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("r_new_mready", {31'h0, mem_ready}, 32'h1);
        chk("r_new_mrdata", mem_rdata, 32'h77778888);
        mem_req = 1'b0;
        @(negedge clk);
        chk("r_new_done", {31'h0, mem_ready}, 32'h0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-master-port arbiter that shares one external memory bus between the instruction-fetch stage and the MEM stage (the consumer of the EX/MEM pipeline register). It serialises at most one outstanding bus transaction at a time, gives data accesses priority over fetches, and returns read data and a one-cycle ready pulse to the winning requester. While a request is unserved it raises a stall request to the pipeline controller. It also runs a watchdog that aborts hung transactions.

## Interface
- TIMEOUT, 255, maximum number of bus cycles without `bus_ack` before abort; legal range 1..255.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until `if_ready`.
- if_addr  in  32  fetch address, word aligned.
- if_rdata  out  32  fetched instruction; valid only while `if_ready` is high.
- if_ready  out  1  one-cycle fetch-complete pulse.
- mem_req  in  1  data request; held high until `mem_ready`.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte enables.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid only while `mem_ready` is high.
- mem_ready  out  1  one-cycle data-complete pulse.
- flush  in  1  pipeline flush; cancels fetch delivery.
- bus_req  out  1  bus strobe.
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/32/32  registered copies of the granted request.
- bus_rdata  in  32  bus read data; sampled when `bus_ack` is high.
- bus_ack  in  1  bus completion.
- bus_err  out  1  one-cycle pulse on watchdog abort.
- stall_req  out  1  `(if_req & ~if_ready) | (mem_req & ~mem_ready)`; combinational.

## Operation
- **States:** IDLE, IF_BUSY, MEM_BUSY, DONE.
- **IDLE:**
  - `mem_req` → MEM_BUSY; latch `mem_*` onto the bus outputs and set `bus_req`.
  - Otherwise `if_req` → IF_BUSY; latch `if_addr`, set `bus_we=0`, `bus_sel=4'hF`.
  - Otherwise stay in IDLE.
  - MEM always wins a simultaneous request.
- **BUSY states:**
  - Bus outputs are held stable.
  - An 8-bit watchdog counter increments every cycle.
  - On `bus_ack`: clear `bus_req`, capture `bus_rdata` into the winner's rdata register, set the winner's ready, go to DONE.
  - If the counter reaches TIMEOUT without ack: clear `bus_req`, pulse `bus_err`, pulse the winner's ready with rdata = 32'h0, go to DONE.
- **DONE:**
  - The winner's ready is high for exactly this cycle.
  - Requests are not sampled.
  - Next state is IDLE unconditionally.
  - This gives requesters one edge to drop or update their req.
- **flush:**
  - Sets a `discard` flag if asserted during IF_BUSY, or in IDLE while a fetch is being granted.
  - The fetch still completes on the bus, because the bus cannot abort it.
  - If `discard` is set, `if_ready` is suppressed in DONE.
  - `discard` clears on entering IDLE.
  - `flush` never affects MEM transactions.
- **Watchdog:** the counter clears on every BUSY entry.
- **Stores:** `mem_rdata` is driven to 32'h0 and the `mem_ready` pulse still occurs.

## Timing
- **Reset** (async, `rst=0`):
  - State = IDLE.
  - `bus_req`, `bus_we`, `if_ready`, `mem_ready`, `bus_err`, `discard` = 0.
  - `bus_sel` = 4'h0.
  - `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata` = 32'h0.
  - Watchdog counter = 0.
- **Reset mid-transaction:** `bus_req` drops immediately (asynchronously); no ready is generated.
- **Latency:**
  - Request sampled in IDLE at edge E0; `bus_req` high from cycle 1.
  - Ack in cycle k (k ≥ 1) gives ready in cycle k+1; IDLE in cycle k+2.
  - Minimum is 3 cycles per access with zero-wait ack.
- **Ack in DONE or IDLE:** ignored.
- **Ack coincident with the timeout cycle:** ack wins; no `bus_err`.
- **Requests arriving while BUSY:** held by the requester and not queued; `stall_req` stays high.
- **MEM starvation of IF:** permitted by design.

## Test plan
- **Single fetch:** `if_req=1`, `if_addr=0x00400000`, ack with rdata `0x24020005` in cycle 2 → `bus_addr=0x00400000` and `bus_we=0` in cycles 1–2; `if_ready=1` and `if_rdata=0x24020005` in cycle 3; IDLE in cycle 4.
- **Simultaneous requests:** `if_req` and `mem_req` (load, `0x10010000`) high together → MEM served first with `mem_ready` pulse; fetch starts in the cycle after DONE; `stall_req` stays high until `if_ready`.
- **Store:** `mem_we=1`, `mem_sel=4'b0011`, `mem_wdata=0xDEADBEEF`, ack after 3 wait cycles → bus outputs stable for all 4 cycles; `mem_ready` for one cycle; `mem_rdata=0`.
- **Flush during fetch:** `flush` pulsed one cycle after the grant; ack arrives → no `if_ready`; then IDLE.
- **Timeout:** TIMEOUT=4, no ack → `bus_err` pulse and ready with rdata=0 in the cycle after the 4th BUSY cycle. A separate case with ack arriving exactly on that 4th cycle → no `bus_err`, normal data.
- **Reset mid-transaction:** `rst` low during MEM_BUSY → all outputs reach reset values without a clock edge. After release, a new request gets normal 3-cycle service.
